axi_line_fill: RTL

Line-fill read engine between the CPU's wide cache-line request port and the AXI read channels. Accepts a request of 1–16 words, issues one INCR AR burst, assembles the 32-bit R beats into a 512-bit line, then returns the line with a one-cycle `data_ok` pulse. Sits on the read path of the CPU-to-AXI bridge. It serves instruction or data line refills; write traffic is handled elsewhere.

---
 rtl/axi_line_fill.sv | 128 ++++++++++++
 1 files changed

// File: rtl/axi_line_fill.sv
// Line-fill read engine: one request becomes one INCR AR burst, and the 32-bit R beats are packed into a 512-bit line.
// Latency from accept to data_ok is N+2 cycles; rvalid gaps stall the beat counter, and requests are ignored while busy.
module axi_line_fill #(
  parameter int         LINE_WORDS = 16,
  parameter logic [3:0] AR_CACHE   = 4'b0000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req,
  input  logic [3:0]                burst,
  input  logic [31:0]               addr,
  output logic                      addr_ok,
  output logic                      data_ok,
  output logic [32*LINE_WORDS-1:0]  line_rdata,
  output logic                      err,
  output logic [31:0]               araddr,
  output logic [7:0]                arlen,
  output logic [2:0]                arsize,
  output logic [1:0]                arburst,
  output logic [3:0]                arcache,
  output logic                      arvalid,
  input  logic                      arready,
  input  logic [31:0]               rdata,
  input  logic [1:0]                rresp,
  input  logic                      rlast,
  input  logic                      rvalid,
  output logic                      rready
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

  state_t                     r_state;
  logic [3:0]                 r_burst;
  logic [3:0]                 r_cnt;
  logic                       r_err;
  logic [32*LINE_WORDS-1:0]   r_line;
  logic [31:0]                r_araddr;
  logic [7:0]                 r_arlen;
  logic                       r_arvalid;
  logic                       r_rready;
  logic                       r_data_ok;

  logic w_beat;
  logic w_cnt_end;
  logic w_end;
  logic w_len_bad;

  assign w_beat    = (r_state == S_DATA) && rvalid && r_rready;
  assign w_cnt_end = (r_cnt == r_burst);
  assign w_end     = w_cnt_end || rlast;
  // Either signal alone ending the burst means the slave and the request disagree on length.
  assign w_len_bad = w_cnt_end != rlast;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_burst   <= 4'd0;
      r_cnt     <= 4'd0;
      r_err     <= 1'b0;
      r_line    <= '0;
      r_araddr  <= 32'd0;
      r_arlen   <= 8'd0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_data_ok <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_burst   <= burst;
            r_cnt     <= 4'd0;
            r_err     <= 1'b0;
            r_line    <= '0;
            r_araddr  <= addr & 32'hFFFF_FFFC;
            r_arlen   <= {4'b0000, burst};
            r_arvalid <= 1'b1;
            r_state   <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_beat) begin
            r_line[{r_cnt, 5'b00000} +: 32] <= rdata;
            if (rresp != 2'b00) begin
              r_err <= 1'b1;
            end
            if (w_end) begin
              if (w_len_bad) begin
                r_err <= 1'b1;
              end
              r_rready  <= 1'b0;
              r_data_ok <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        S_DONE: begin
          r_data_ok <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign addr_ok    = (r_state == S_IDLE);
  assign data_ok    = r_data_ok;
  assign line_rdata = r_line;
  assign err        = r_err;
  assign araddr     = r_araddr;
  assign arlen      = r_arlen;
  assign arsize     = 3'b010;
  assign arburst    = 2'b01;
  assign arcache    = AR_CACHE;
  assign arvalid    = r_arvalid;
  assign rready     = r_rready;

endmodule
